// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetchState_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetchEntry_t;

    // A fetch PC is illegal if it is not word aligned or lies above the implemented space.
    function automatic logic pc_illegal(input logic [31:0] pc, input int unsigned addr_width);
        logic [31:0] hi_mask;
        hi_mask = (addr_width >= 32) ? 32'h0 : ~((32'h1 << addr_width) - 32'h1);
        return (pc[1:0] != 2'b00) || ((pc & hi_mask) != 32'h0);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instruction, pc} entries with flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetchEntry_t                  push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_valid,
    output fetchEntry_t                  head_entry,
    output logic [$clog2(BUF_DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    fetchEntry_t      mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && !flush && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        head_valid = (count_q != '0);
        head_entry = head_valid ? mem_q[rd_ptr_q] : '{instr: NOP_INSTR, pc: 32'h0};
        occupancy  = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, redirect/flush, fault detection and decode handshake.
// Define FETCH_PERF_EN to add the issueCount/stallCount performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchEnable,
    output logic [31:0] pcAddress,
    input  logic [31:0] pcDataOutput,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instruction,
    output logic [31:0] instrPc,
    output logic        fault,
    output logic [31:0] faultPc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] issueCount,
    output logic [31:0] stallCount
`endif
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned INF_W = OCC_W + 1;

    fetchState_t state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic             pop, push, do_issue, attempt, issue_bad, space_ok;
    logic [31:0]      issue_pc;
    logic [OCC_W-1:0] occupancy;
    logic [INF_W-1:0] inflight;
    fetchEntry_t      head_entry;

    always_comb begin
        pop       = instrValid && instrReady;
        issue_pc  = redirect ? redirectTarget : fetch_pc_q;
        issue_bad = pc_illegal(issue_pc, ADDR_WIDTH);
        inflight  = INF_W'(occupancy) + INF_W'(pending_q) - INF_W'(pop);
        // A redirect flushes everything, so the target always has room.
        space_ok  = redirect || (inflight < INF_W'(BUF_DEPTH));
        attempt   = fetchEnable && space_ok &&
                    ((state_q == RUN) || ((state_q == FAULT) && redirect));

        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        do_issue     = 1'b0;

        if ((attempt || redirect) && issue_bad) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = issue_pc;
            if (redirect) begin
                fetch_pc_d = redirectTarget;
            end
        end else begin
            if (redirect) begin
                fault_d    = 1'b0;
                fetch_pc_d = redirectTarget;
                state_d    = fetchEnable ? RUN : IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (fetchEnable)  state_d = RUN;
                    RUN:     if (!fetchEnable) state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
            if (attempt) begin
                do_issue   = 1'b1;
                fetch_pc_d = issue_pc + 32'(INSTR_BYTES);
            end
        end

        pending_d    = do_issue;
        pending_pc_d = do_issue ? issue_pc : pending_pc_q;
        pcAddress    = do_issue ? issue_pc : fetch_pc_q;
        // Data returning for a fetch issued before a redirect is dropped.
        push         = pending_q && !redirect;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
            fault_q      <= 1'b0;
            fault_pc_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{instr: pcDataOutput, pc: pending_pc_q}),
        .pop        (pop),
        .flush      (redirect),
        .head_valid (instrValid),
        .head_entry (head_entry),
        .occupancy  (occupancy)
    );

    assign instruction = head_entry.instr;
    assign instrPc     = head_entry.pc;
    assign fault       = fault_q;
    assign faultPc     = fault_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] issue_count_q, issue_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        issue_count_d = issue_count_q + 32'(do_issue);
        stall_count_d = stall_count_q + 32'((state_q == RUN) && !do_issue);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            issue_count_q <= issue_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign issueCount = issue_count_q;
    assign stallCount = stall_count_q;
`endif

endmodule
